// File: rtl/vga_timing_ovl_gen_pkg.sv
// vga_pkg: shared box record, timing helper functions and colour-bar table
// for the VGA timing / box overlay generator.
package vga_pkg;

    // rgb field is sized for the widest supported colour (3 x 16 bits);
    // the top level zero-extends on write and slices on read.
    localparam int RGB_MAX_W = 48;

    typedef struct packed {
        logic                 en;
        logic [10:0]          x0;
        logic [10:0]          x1;
        logic [9:0]           y0;
        logic [9:0]           y1;
        logic [RGB_MAX_W-1:0] rgb;
    } box_t;

    function automatic int line_total(int syn, int bp, int act, int fp);
        return syn + bp + act + fp;
    endfunction

    function automatic int active_start(int syn, int bp);
        return syn + bp;
    endfunction

    // {R,G,B} on/off per bar, index 0 = leftmost
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000,   // 7 black
        3'b001,   // 6 blue
        3'b100,   // 5 red
        3'b101,   // 4 magenta
        3'b010,   // 3 green
        3'b011,   // 2 cyan
        3'b110,   // 1 yellow
        3'b111    // 0 white
    };

endpackage

// File: rtl/vga_timing_ovl_gen_if.sv
// Box programming bus: writes one shadow box entry per strobe.
interface vga_timing_ovl_gen_if #(
    parameter int COLOR_W = 8
);
    logic                   iBox_we;
    logic [1:0]             iBox_sel;
    logic                   iBox_en;
    logic [10:0]            iBox_x0;
    logic [10:0]            iBox_x1;
    logic [9:0]             iBox_y0;
    logic [9:0]             iBox_y1;
    logic [3*COLOR_W-1:0]   iBox_rgb;

    modport master (output iBox_we, iBox_sel, iBox_en, iBox_x0, iBox_x1,
                           iBox_y0, iBox_y1, iBox_rgb);
    modport slave  (input  iBox_we, iBox_sel, iBox_en, iBox_x0, iBox_x1,
                           iBox_y0, iBox_y1, iBox_rgb);
endinterface

// File: rtl/vga_timing_ovl_gen_box_hit.sv
// vga_box_hit: combinational outline hit test for one rectangle.
// An inverted box (x0>x1 or y0>y1) fails the range test and never hits.
module vga_box_hit
    import vga_pkg::*;
#(
    parameter int BOX_THK = 1
) (
    input  logic [10:0] x_i,
    input  logic [9:0]  y_i,
    input  box_t        box_i,
    output logic        hit_o
);
    logic in_x, in_y, near_x, near_y;
    logic unused_rgb;

    assign in_x   = (box_i.x0 <= x_i) && (x_i <= box_i.x1);
    assign in_y   = (box_i.y0 <= y_i) && (y_i <= box_i.y1);
    // compare with one extra bit so x0+THK / x+THK cannot wrap
    assign near_x = ({1'b0, x_i} < {1'b0, box_i.x0} + 12'(BOX_THK)) ||
                    ({1'b0, x_i} + 12'(BOX_THK) > {1'b0, box_i.x1});
    assign near_y = ({1'b0, y_i} < {1'b0, box_i.y0} + 11'(BOX_THK)) ||
                    ({1'b0, y_i} + 11'(BOX_THK) > {1'b0, box_i.y1});
    assign hit_o  = box_i.en && in_x && in_y && (near_x || near_y);

    assign unused_rgb = ^box_i.rgb;
endmodule

// File: rtl/vga_timing_ovl_gen.sv
// vga_timing_ovl_gen: VGA H/V timing, lead-compensated pixel request and
// up to NUM_BOX double-buffered rectangle outlines over the video.
// Optional macro VGA_TEST_PATTERN_EN adds iPattern to replace input video.
module vga_timing_ovl_gen
    import vga_pkg::*;
#(
    parameter int H_ACT    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYN    = 96,
    parameter int H_BP     = 48,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYN    = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int REQ_LEAD = 2,
    parameter int COLOR_W  = 8,
    parameter int NUM_BOX  = 2,
    parameter int BOX_THK  = 1
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
`ifdef VGA_TEST_PATTERN_EN
    input  logic [1:0]         iPattern,
`endif
    vga_timing_ovl_gen_if.slave box_if,
    output logic               oRequest,
    output logic [10:0]        oReq_X,
    output logic [9:0]         oReq_Y,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_H_SYNC,
    output logic               oVGA_V_SYNC,
    output logic               oVGA_BLANK,
    output logic               oVGA_SYNC,
    output logic               oFrame_start,
    output logic [12:0]        H_Cont,
    output logic [12:0]        V_Cont
);
    localparam int H_TOT = line_total(H_SYN, H_BP, H_ACT, H_FP);
    localparam int V_TOT = line_total(V_SYN, V_BP, V_ACT, V_FP);
    localparam int HA0   = active_start(H_SYN, H_BP);
    localparam int VA0   = active_start(V_SYN, V_BP);
    localparam int CW3   = 3 * COLOR_W;

    logic [12:0]              h_q, h_d, v_q, v_d;
    logic                     h_wrap, frame_end, h_act, v_act, de;
    logic [13:0]              h_lead;
    logic [10:0]              x_pix;
    logic [9:0]               y_pix;
    box_t                     wr_box;
    box_t [NUM_BOX-1:0]       shadow_q, shadow_d, live_q, live_d;
    logic [NUM_BOX-1:0]       hit;
    logic                     ovl_hit;
    logic [CW3-1:0]           ovl_rgb, src_rgb, rgb_q;
    logic                     hs_q, vs_q, blank_q, fs_q;
    logic                     unused_rgb_hi;

    // next counter values; V advances only on the H wrap
    always_comb begin
        h_wrap    = (h_q == 13'(H_TOT - 1));
        frame_end = h_wrap && (v_q == 13'(V_TOT - 1));
        h_d       = h_wrap ? 13'd0 : h_q + 13'd1;
        v_d       = v_q;
        if (h_wrap) v_d = (v_q == 13'(V_TOT - 1)) ? 13'd0 : v_q + 13'd1;
    end

    assign h_act  = (h_q >= 13'(HA0)) && (h_q < 13'(HA0 + H_ACT));
    assign v_act  = (v_q >= 13'(VA0)) && (v_q < 13'(VA0 + V_ACT));
    assign de     = h_act && v_act;
    assign x_pix  = 11'(h_q - 13'(HA0));
    assign y_pix  = 10'(v_q - 13'(VA0));

    // lead window ends with the active window, so requests stay in-line
    assign h_lead   = {1'b0, h_q} + 14'(REQ_LEAD);
    assign oRequest = v_act && (h_lead >= 14'(HA0)) && (h_lead < 14'(HA0 + H_ACT));
    assign oReq_X   = oRequest ? 11'(h_lead - 14'(HA0)) : 11'd0;
    assign oReq_Y   = oRequest ? y_pix : 10'd0;

    // shadow write, and commit at the last pixel with the write bypassed in
    always_comb begin
        wr_box.en  = box_if.iBox_en;
        wr_box.x0  = box_if.iBox_x0;
        wr_box.x1  = box_if.iBox_x1;
        wr_box.y0  = box_if.iBox_y0;
        wr_box.y1  = box_if.iBox_y1;
        wr_box.rgb = RGB_MAX_W'(box_if.iBox_rgb);
        shadow_d   = shadow_q;
        for (int i = 0; i < NUM_BOX; i++)
            if (box_if.iBox_we && box_if.iBox_sel == 2'(i)) shadow_d[i] = wr_box;
        live_d = frame_end ? shadow_d : live_q;
    end

    for (genvar g = 0; g < NUM_BOX; g++) begin : g_box
        vga_box_hit #(.BOX_THK(BOX_THK)) u_hit (
            .x_i   (x_pix),
            .y_i   (y_pix),
            .box_i (live_q[g]),
            .hit_o (hit[g])
        );
    end

    // priority mux: scan high to low so the lowest hitting index wins
    always_comb begin
        ovl_hit       = 1'b0;
        ovl_rgb       = '0;
        unused_rgb_hi = 1'b0;
        for (int i = NUM_BOX - 1; i >= 0; i--) begin
            unused_rgb_hi = unused_rgb_hi ^ (^live_q[i].rgb);
            if (hit[i]) begin
                ovl_hit = 1'b1;
                ovl_rgb = live_q[i].rgb[CW3-1:0];
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACT / 8 > 0) ? H_ACT / 8 : 1;
    logic [10:0] bar_idx;
    logic [2:0]  bar;

    // source video: pass-through, colour bars, 32-pixel grid or mid-grey
    always_comb begin
        bar_idx = x_pix / 11'(BAR_W);
        bar     = (bar_idx > 11'd7) ? BAR_RGB[7] : BAR_RGB[bar_idx[2:0]];
        case (iPattern)
            2'd1:    src_rgb = {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}};
            2'd2:    src_rgb = (x_pix[4:0] == 5'd0 || y_pix[4:0] == 5'd0) ? '1 : '0;
            2'd3:    src_rgb = {3{1'b1, {(COLOR_W-1){1'b0}}}};
            default: src_rgb = {iRed, iGreen, iBlue};
        endcase
    end
`else
    assign src_rgb = {iRed, iGreen, iBlue};
`endif

    // counters and box banks
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            h_q      <= '0;
            v_q      <= '0;
            shadow_q <= '0;
            live_q   <= '0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            shadow_q <= shadow_d;
            live_q   <= live_d;
        end
    end

    // single output register keeps sync, blank and colour aligned
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rgb_q   <= '0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            rgb_q   <= de ? (ovl_hit ? ovl_rgb : src_rgb) : '0;
            hs_q    <= (h_q < 13'(H_SYN)) ? SYNC_POL : ~SYNC_POL;
            vs_q    <= (v_q < 13'(V_SYN)) ? SYNC_POL : ~SYNC_POL;
            blank_q <= de;
            fs_q    <= (h_q == 13'd0) && (v_q == 13'd0);
        end
    end

    assign {oVGA_R, oVGA_G, oVGA_B} = rgb_q;
    assign oVGA_H_SYNC  = hs_q;
    assign oVGA_V_SYNC  = vs_q;
    assign oVGA_BLANK   = blank_q;
    assign oVGA_SYNC    = 1'b0;
    assign oFrame_start = fs_q;
    assign H_Cont       = h_q;
    assign V_Cont       = v_q;
endmodule

// File: doc/vga_timing_ovl_gen.md
Name: vga_timing_ovl_gen

Overview:
- Parametrised successor to the camera-path VGA timing controller, sitting between the frame-buffer read side and the DAC/ADV7123 pins.
- Generates H/V counters, sync, blank and a lead-compensated pixel request.
- Draws up to NUM_BOX runtime-programmable rectangle outlines over the video, replacing the fixed green grid.
- Box registers are double-buffered and applied at frame start, so there is no tearing.

Parameters:
H_ACT, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYN, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACT, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYN, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 0, active level of both sync outputs
REQ_LEAD, 2, clocks between oRequest and valid iRed/iGreen/iBlue (0..15)
COLOR_W, 8, bits per colour channel
NUM_BOX, 2, overlay rectangles (1..4)
BOX_THK, 1, outline thickness in pixels

Ports:
iCLK  in  1  pixel clock
iRST  in  1  synchronous active-high reset
iRed/iGreen/iBlue  in  COLOR_W each  pixel data, valid REQ_LEAD clocks after oRequest
iBox_we  in  1  write strobe for shadow box registers
iBox_sel  in  2  box index (writes with index >= NUM_BOX are ignored)
iBox_en  in  1  box enable
iBox_x0/iBox_x1  in  11 each  left/right, active coordinates, inclusive
iBox_y0/iBox_y1  in  10 each  top/bottom, inclusive
iBox_rgb  in  3*COLOR_W  outline colour {R,G,B}
oRequest  out  1  pixel fetch request
oReq_X/oReq_Y  out  11/10  active coordinate being requested
oVGA_R/G/B  out  COLOR_W each  registered colour
oVGA_H_SYNC, oVGA_V_SYNC, oVGA_BLANK, oVGA_SYNC  out  1 each
oFrame_start  out  1  one-clock pulse at H=0, V=0
H_Cont/V_Cont  out  13 each  raw counters

Behaviour:
- Reset (synchronous, iRST=1 sampled on iCLK): counters=0, oRequest=0, oVGA_R/G/B=0, syncs=~SYNC_POL, oVGA_BLANK=0, oFrame_start=0, all shadow and live boxes disabled.
- Geometry: H_TOT=H_SYN+H_BP+H_ACT+H_FP. H_Cont counts 0..H_TOT-1 exactly, then wraps. V_Cont increments when H_Cont wraps, counts 0..V_TOT-1 and wraps.
- Line layout: sync [0,H_SYN); back porch; active [HA0=H_SYN+H_BP, HA0+H_ACT); front porch. Vertical layout is the same with VA0.
- Combinational video-enable de = both counters in their active windows.
- oRequest is asserted when (H_Cont+REQ_LEAD) is in the H active window AND V_Cont is in the V active window.
  - oReq_X = H_Cont+REQ_LEAD-HA0; oReq_Y = V_Cont-VA0; both 0 when oRequest=0.
  - Requests never cross a line boundary.
- Output stage: one register. Sync, blank and colour computed from cycle-t counters appear at t+1, so all outputs stay mutually aligned.
  - oVGA_BLANK=de (1 = visible). Colour = 0 when de=0. oVGA_SYNC tied 0.
- Overlay, at active position (x,y), box i hits when live_en[i] and x0<=x<=x1 and y0<=y<=y1 and the pixel lies within BOX_THK of any edge.
  - The lowest hit index wins and replaces the input colour.
  - x0>x1 or y0>y1 means the box never hits. Coordinates beyond the active area are clipped naturally.
- Box write: when iBox_we=1, the shadow entry [iBox_sel] takes all box fields on that clock.
- Box commit: live registers load from shadow on the clock where H_Cont=H_TOT-1 and V_Cont=V_TOT-1. A write on that same clock is committed too (shadow write bypasses into live).
- Reset mid-frame: counters restart at 0 on the next clock; no partial pulse on oFrame_start.

Optional Feature:
- VGA_TEST_PATTERN_EN defined: adds input iPattern [1:0], which replaces input data before the overlay is applied.
  - 0 = pass-through.
  - 1 = 8 vertical colour bars, each H_ACT/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black.
  - 2 = 1-pixel white grid every 32 pixels.
  - 3 = solid mid-grey (MSB only).
- Undefined: the port is absent and the input data always passes through.

Decomposition:
- Package vga_pkg: box_t struct (en, x0, x1, y0, y1, rgb), the H_TOT/V_TOT/HA0/VA0 localparam functions, and the bar colour constants.
- Sub-module vga_box_hit (one instance per box): combinational hit test from (x, y, box_t, BOX_THK).
- The top level holds the counters, shadow/live registers, priority mux and output register.

Test Plan:
- Reduced timing H_ACT=8, H_FP=2, H_SYN=3, H_BP=2, V_ACT=4, V_FP=1, V_SYN=1, V_BP=1, REQ_LEAD=2 -> H_TOT=15, V_TOT=7; oRequest high H_Cont 3..10, oReq_X 0..7; oVGA_BLANK high one clock later, for H_Cont 5..12 delayed by 1.
- Check oFrame_start period = 105 clocks; H sync low for 3 clocks per line (SYNC_POL=0).
- Write box 0 {en=1, x0=2, x1=5, y0=1, y1=2, rgb=00FF00} mid-frame -> no change in the current frame. Next frame, outline pixels (2..5,1),(2..5,2) are green and all other pixels pass input.
- Boxes 0 and 1 overlapping, box1 red, box0 green -> overlap pixels are green. Box with x0=6, x1=3 -> never drawn.
- Assert iRST at H_Cont=7, V_Cont=2 for 1 clock -> next clock counters=0, colour=0, syncs inactive, live boxes disabled.
- With VGA_TEST_PATTERN_EN, iPattern=1, H_ACT=640 -> pixel x=80 is yellow FFFF00 and x=639 is black.
